// File: rtl/display_io_b3_pkg.sv
// Shared definitions for the Basys3 seven-segment driver: segment patterns,
// special display codes and the display mode enum.
package display_io_b3_pkg;

    typedef enum logic {
        MODE_PATTERN = 1'b0,
        MODE_RAW     = 1'b1
    } disp_mode_e;

    // Active-high gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam logic [6:0] SEG_DASH   = 7'h40;
    localparam logic [7:0] CODE_BLANK = 8'h10;
    localparam logic [7:0] CODE_DASH  = 8'h11;

    function automatic logic [6:0] seg_decode(input logic [7:0] code);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (code[7:4] == 4'h0)
            pat = SEG_HEX[code[3:0]];
        else if (code == CODE_DASH)
            pat = SEG_DASH;
        return pat;
    endfunction

endpackage

// File: rtl/display_io_b3_prescaler.sv
// Free-running power-of-two prescaler; out toggles every 2^(N-1) clocks.
// Also shared by the input debouncer, so it carries no display-specific logic.
module prescaler #(
    parameter int N = 21
) (
    input  logic clk,
    input  logic reset,
    output logic out
);

    localparam logic [N-1:0] ONE = 1;

    logic [N-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + ONE;
    end

    assign out = r_cnt[N-1];

endmodule

// File: rtl/display_io_b3.sv
// Four-digit multiplexed 7-segment driver: one digit per prescaler tick,
// with registered active-low segment, decimal-point and anode outputs.
module display_io_b3
    import display_io_b3_pkg::*;
#(
    parameter int SCAN_N = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_ctrl,
    input  logic [7:0] disp0,
    input  logic [7:0] disp1,
    input  logic [7:0] disp2,
    input  logic [7:0] disp3,
    input  logic [3:0] dp_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    logic       w_scan_clk;
    logic       w_tick;
    logic       r_scan_prev;
    logic [1:0] r_idx;
    logic [7:0] w_code;
    logic [6:0] w_seg_n;

    prescaler #(.N(SCAN_N)) u_scan_ps (
        .clk   (clk),
        .reset (reset),
        .out   (w_scan_clk)
    );

    // Rising edge of the prescaler output used as a clock enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_scan_prev <= 1'b0;
        else
            r_scan_prev <= w_scan_clk;
    end

    assign w_tick = w_scan_clk & ~r_scan_prev;

    always_comb begin
        w_code = disp0;
        case (r_idx)
            2'd0: w_code = disp0;
            2'd1: w_code = disp1;
            2'd2: w_code = disp2;
            2'd3: w_code = disp3;
            default: w_code = disp0;
        endcase
    end

    assign w_seg_n = (disp_mode_e'(display_ctrl) == MODE_RAW) ? ~w_code[6:0]
                                                              : ~seg_decode(w_code);

    // r_idx names the digit loaded on the next tick, so digit 0 is shown first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 2'd0;
            an    <= 4'b1111;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else if (w_tick) begin
            an    <= ~(4'b0001 << r_idx);
            seg   <= w_seg_n;
            dp    <= ~dp_in[r_idx];
            r_idx <= r_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_display_io_b3.sv
// Bench for display_io_b3 (SCAN_N = 2) plus a standalone prescaler (N = 3).
module tb_display_io_b3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       display_ctrl = 1'b0;
    logic [7:0] disp0 = '0, disp1 = '0, disp2 = '0, disp3 = '0;
    logic [3:0] dp_in = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       ps_out;

    int total = 0;
    int bad   = 0;
    int exp_idx = 0;

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    display_io_b3 #(.SCAN_N(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .display_ctrl (display_ctrl),
        .disp0        (disp0),
        .disp1        (disp1),
        .disp2        (disp2),
        .disp3        (disp3),
        .dp_in        (dp_in),
        .seg          (seg),
        .dp           (dp),
        .an           (an)
    );

    prescaler #(.N(3)) u_ps (
        .clk   (clk),
        .reset (reset),
        .out   (ps_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    function automatic logic [7:0] disp_of(input int k);
        case (k)
            0: return disp0;
            1: return disp1;
            2: return disp2;
            default: return disp3;
        endcase
    endfunction

    // Reference: lit segments from the mode rules, then invert for the pins
    function automatic logic [6:0] exp_seg(input int k);
        logic [7:0] c;
        logic [6:0] lit;
        c = disp_of(k);
        if (display_ctrl)      lit = c[6:0];
        else if (c < 8'd16)    lit = hex_tbl[c[3:0]];
        else if (c == 8'h11)   lit = 7'h40;
        else                   lit = 7'h00;
        return ~lit;
    endfunction

    task automatic next_update(input bit chk_int);
        logic [3:0] prev;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int n;
        prev = an;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an === prev && n < 12);
        check("update_timeout", 32'(n < 12), 32'd1);
        if (chk_int) check("scan_interval", n, 4);
        e_an  = ~(4'b0001 << exp_idx);
        e_seg = exp_seg(exp_idx);
        e_dp  = ~dp_in[exp_idx];
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("dp", dp, e_dp);
        exp_idx = (exp_idx + 1) % 4;
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an"}, an, 4'b1111);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_dp"}, dp, 1'b1);
    endtask

    initial begin
        logic e_ps;
        repeat (3) @(negedge clk);
        check_blank("rst");
        check("rst_ps", ps_out, 1'b0);

        // Standalone prescaler: low for 4 clocks, high for 4
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            e_ps = ((k % 8) >= 4);
            check("ps_out", ps_out, e_ps);
            if (k == 1) check("an_pre_tick", an, 4'b1111);
        end

        // Asynchronous reset while scanning and while ps_out is high
        #2 reset = 1'b1;
        #1;
        check_blank("async_rst");
        check("async_rst_ps", ps_out, 1'b0);

        // Pattern mode directed values
        disp0 = 8'h05; disp1 = 8'h10; disp2 = 8'h0A; disp3 = 8'h11;
        dp_in = 4'b0100; display_ctrl = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_idx = 0;
        @(negedge clk);
        check("an_blank_after_rel", an, 4'b1111);
        next_update(1'b0);
        check("pat_d0_seg", seg, 7'b0010010);
        next_update(1'b1);
        check("pat_d1_blank", seg, 7'b1111111);
        next_update(1'b1);
        check("dp_d2", dp, 1'b0);
        next_update(1'b1);
        check("pat_d3_dash", seg, 7'b0111111);
        check("an_d3", an, 4'b0111);
        next_update(1'b1);
        check("an_wrap", an, 4'b1110);

        // Raw mode: bit 7 ignored
        display_ctrl = 1'b1;
        disp2 = 8'h49;
        next_update(1'b1);
        next_update(1'b1);
        check("raw_49", seg, 7'b0110110);
        disp2 = 8'hC9;
        repeat (4) next_update(1'b1);
        check("raw_c9", seg, 7'b0110110);

        // Randomized inputs, changed only between updates
        for (int i = 0; i < 40; i++) begin
            display_ctrl = 1'($urandom_range(0, 1));
            dp_in = 4'($urandom);
            disp0 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 19)) : 8'($urandom);
            disp1 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 19)) : 8'($urandom);
            disp2 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 19)) : 8'($urandom);
            disp3 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 19)) : 8'($urandom);
            next_update(1'b1);
        end

        // Reset mid-scan while digit 2 is lit
        while (exp_idx != 3) next_update(1'b1);
        check("an_before_midrst", an, 4'b1011);
        #2 reset = 1'b1;
        #1;
        check_blank("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        exp_idx = 0;
        next_update(1'b0);
        check("restart_an", an, 4'b1110);
        next_update(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
